joy_scan_ctrl: RTL and testbench

//  Sequencer for the external parallel-in/serial-out joystick chain: drives load and

---
 rtl/joy_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_joy_scan_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/joy_scan_ctrl.sv
// joy_scan_ctrl: sequencer for a parallel-in/serial-out joystick chain with double-buffered frame output
// Ports:
//   clk, reset_n       system clock, asynchronous active-low reset
//   continuous         1 = rescan back-to-back, 0 = one frame per scan_req
//   scan_req           level start request, only looked at while idle
//   joy_data           serial data from the chain
//   joy_clk            registered serial shift clock
//   joy_load_n         registered parallel load strobe, active low
//   frame              last complete frame, bit0 = first bit sampled
//   frame_valid        one-cycle pulse when frame updates
//   frame_changed      one-cycle pulse with frame_valid when the new frame differs
//   busy               high whenever not idle
module joy_scan_ctrl #(
    parameter int CLK_DIV   = 128,
    parameter int NBITS     = 16,
    parameter int GAP_TICKS = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             continuous,
    input  logic             scan_req,
    input  logic             joy_data,
    output logic             joy_clk,
    output logic             joy_load_n,
    output logic [NBITS-1:0] frame,
    output logic             frame_valid,
    output logic             frame_changed,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
    localparam int DW   = $clog2(CLK_DIV);
    localparam int CMAX = (NBITS > GAP_TICKS ? NBITS : GAP_TICKS) > 2 ?
                          (NBITS > GAP_TICKS ? NBITS : GAP_TICKS) : 2;
    localparam int CW   = $clog2(CMAX);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    state_t           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ph_q, ph_d;
    logic [NBITS-1:0] shadow_q, shadow_d, frame_q, frame_d;
    logic             valid_q, valid_d, changed_q, changed_d;
    logic             jclk_q, jclk_d, load_n_q, load_n_d, busy_q, busy_d;
    logic             tick;
    assign tick = div_q == DIV_LAST;
    always_comb begin
        state_d   = state_q;
        div_d     = tick ? '0 : div_q + 1'b1;
        cnt_d     = cnt_q;
        ph_d      = ph_q;
        shadow_d  = shadow_q;
        frame_d   = frame_q;
        valid_d   = 1'b0;
        changed_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                div_d = '0;
                cnt_d = '0;
                ph_d  = 1'b0;
                if (continuous || scan_req) state_d = LOAD;
            end
            LOAD: if (tick) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    ph_d    = 1'b0;
                end
            end
            SHIFT: if (tick) begin
                ph_d = ~ph_q;
                // shift in from the top so the first sample lands in bit0 after NBITS bits
                if (!ph_q) shadow_d = NBITS'({joy_data, shadow_q} >> 1);
                else if (cnt_q == CW'(NBITS - 1)) begin
                    state_d   = GAP;
                    cnt_d     = '0;
                    frame_d   = shadow_q;
                    valid_d   = 1'b1;
                    changed_d = shadow_q != frame_q;
                end else cnt_d = cnt_q + 1'b1;
            end
            GAP: if (tick) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(GAP_TICKS - 1)) begin
                    cnt_d   = '0;
                    state_d = continuous ? LOAD : IDLE;
                end
            end
        endcase
        // pin outputs are registered copies of what the next state implies
        load_n_d = state_d != LOAD;
        jclk_d   = (state_d == SHIFT) && ph_d;
        busy_d   = state_d != IDLE;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            div_q     <= '0;
            cnt_q     <= '0;
            ph_q      <= 1'b0;
            shadow_q  <= '1;
            frame_q   <= '1;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            jclk_q    <= 1'b0;
            load_n_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            ph_q      <= ph_d;
            shadow_q  <= shadow_d;
            frame_q   <= frame_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            jclk_q    <= jclk_d;
            load_n_q  <= load_n_d;
            busy_q    <= busy_d;
        end
    end
    assign joy_clk       = jclk_q;
    assign joy_load_n    = load_n_q;
    assign frame         = frame_q;
    assign frame_valid   = valid_q;
    assign frame_changed = changed_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_joy_scan_ctrl.sv
// tb_joy_scan_ctrl: self-checking bench for joy_scan_ctrl against a 165-style shift register model
module tb_joy_scan_ctrl;
    localparam int CD  = 4;
    localparam int NB  = 16;
    localparam int GT  = 4;
    localparam int LAT = (2 + 2 * NB) * CD;
    localparam int PER = (2 + 2 * NB + GT) * CD;
    logic          clk = 1'b0, reset_n = 1'b0, continuous = 1'b0, scan_req = 1'b0;
    logic          joy_data, joy_clk, joy_load_n, frame_valid, frame_changed, busy;
    logic [NB-1:0] frame;
    joy_scan_ctrl #(.CLK_DIV(CD), .NBITS(NB), .GAP_TICKS(GT)) dut (
        .clk(clk), .reset_n(reset_n), .continuous(continuous), .scan_req(scan_req),
        .joy_data(joy_data), .joy_clk(joy_clk), .joy_load_n(joy_load_n), .frame(frame),
        .frame_valid(frame_valid), .frame_changed(frame_changed), .busy(busy)
    );
    always #5 clk = ~clk;
    // chain model: parallel load while load_n is low, shift toward bit0 on each rising joy_clk
    logic [NB-1:0] model_data = '0, sr = '1;
    logic          mclk_q = 1'b0;
    assign joy_data = sr[0];
    always @(posedge clk) begin
        mclk_q <= joy_clk;
        if (!joy_load_n) sr <= model_data;
        else if (joy_clk && !mclk_q) sr <= {1'b1, sr[NB-1:1]};
    end
    typedef struct {logic [NB-1:0] f; logic ch;} exp_t;
    typedef struct {logic [NB-1:0] data; logic ch;} vec_t;
    exp_t sb[$];
    exp_t mon_e;
    int   nvec = 0, nerr = 0, cyc = 0;
    int   rises = 0, lows = 0, fv_n = 0, fv_cyc = 0, first_low = 0;
    logic pclk = 1'b0, pload = 1'b1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (reset_n) begin
            if (joy_clk && !pclk) rises++;
            if (!joy_load_n) begin
                lows++;
                if (pload) first_low = cyc;
            end
            if (frame_valid) begin
                fv_n++;
                fv_cyc = cyc;
                if (sb.size() == 0) chk("unexpected_frame_valid", 1, 0);
                else begin
                    mon_e = sb.pop_front();
                    chk("frame", 32'(frame), 32'(mon_e.f));
                    chk("frame_changed", 32'(frame_changed), 32'(mon_e.ch));
                end
            end
        end
        pclk  = joy_clk;
        pload = joy_load_n;
    end
    task automatic wait_fv(input int target, input string name);
        for (int i = 0; i < 4 * PER; i++) begin
            @(negedge clk); #1;
            if (fv_n >= target) break;
        end
        chk(name, fv_n, target);
    endtask
    task automatic wait_rises(input int target);
        for (int i = 0; i < 2 * PER; i++) begin
            @(negedge clk); #1;
            if (rises >= target) break;
        end
        chk("rise_wait", rises, target);
    endtask
    task automatic wait_idle(input string name);
        for (int i = 0; i < 4 * PER; i++) begin
            @(negedge clk); #1;
            if (!busy) break;
        end
        chk(name, busy, 0);
    endtask
    task automatic pulse_req();
        @(negedge clk);
        scan_req = 1'b1;
        @(negedge clk);
        scan_req = 1'b0;
    endtask
    vec_t tbl[5];
    initial begin
        int k, b_r, b_l, t1, tgt;
        tbl[0] = '{16'hA5C3, 1'b1};
        tbl[1] = '{16'hA5C3, 1'b0};
        tbl[2] = '{16'h0000, 1'b1};
        tbl[3] = '{16'hFFFF, 1'b1};
        tbl[4] = '{16'h5A5A, 1'b1};
        repeat (3) @(negedge clk);
        chk("rst_joy_clk", joy_clk, 0);
        chk("rst_load_n", joy_load_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_frame", frame, 16'hFFFF);
        chk("rst_valid", frame_valid, 0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_after_rst", busy, 0);
        foreach (tbl[i]) begin
            model_data = tbl[i].data;
            sb.push_back('{tbl[i].data, tbl[i].ch});
            b_r = rises;
            b_l = lows;
            tgt = fv_n + 1;
            @(negedge clk);
            scan_req = 1'b1;
            @(posedge clk); #1;
            k = cyc;
            scan_req = 1'b0;
            wait_fv(tgt, "single_fv");
            wait_idle("single_idle");
            chk("load_start", first_low, k);
            chk("fv_latency", fv_cyc, k + LAT);
            chk("load_len", lows - b_l, 2 * CD);
            chk("rise_count", rises - b_r, NB);
        end
        model_data = 16'h1234;
        sb.push_back('{16'h1234, 1'b1});
        tgt = fv_n + 1;
        @(negedge clk);
        continuous = 1'b1;
        wait_fv(tgt, "cont_fv1");
        t1 = fv_cyc;
        sb.push_back('{16'h1234, 1'b0});
        wait_fv(tgt + 1, "cont_fv2");
        chk("cont_period", fv_cyc - t1, PER);
        t1 = fv_cyc;
        model_data = 16'h1235;
        sb.push_back('{16'h1235, 1'b1});
        wait_fv(tgt + 2, "cont_fv3");
        chk("cont_period", fv_cyc - t1, PER);
        t1 = fv_cyc;
        sb.push_back('{16'h1235, 1'b0});
        b_r = rises;
        wait_rises(b_r + 8);
        continuous = 1'b0;
        wait_fv(tgt + 3, "drop_fv");
        chk("drop_period", fv_cyc - t1, PER);
        wait_idle("drop_idle");
        chk("drop_rises", rises - b_r, NB);
        b_l = lows;
        repeat (2 * PER) @(negedge clk);
        chk("drop_no_load", lows - b_l, 0);
        chk("drop_no_fv", fv_n, tgt + 3);
        model_data = 16'h0F0F;
        sb.push_back('{16'h0F0F, 1'b1});
        tgt = fv_n + 1;
        b_r = rises;
        pulse_req();
        wait_rises(b_r + 3);
        pulse_req();
        wait_fv(tgt, "busy_req_fv");
        pulse_req();
        wait_idle("busy_req_idle");
        repeat (3 * PER) @(negedge clk);
        chk("busy_req_one_frame", fv_n, tgt);
        chk("busy_req_idle2", busy, 0);
        model_data = 16'h3C3C;
        b_r = rises;
        pulse_req();
        wait_rises(b_r + 5);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("arst_joy_clk", joy_clk, 0);
        chk("arst_load_n", joy_load_n, 1);
        chk("arst_busy", busy, 0);
        chk("arst_frame", frame, 16'hFFFF);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        tgt = fv_n;
        repeat (PER) @(negedge clk);
        chk("arst_stay_idle", busy, 0);
        chk("arst_load_idle", joy_load_n, 1);
        chk("arst_no_fv", fv_n, tgt);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
